// File: rtl/pl_reg_e2m.sv
// Execute->Memory pipeline register with an integrated data-memory access
// sequencer. Captures execute results, runs at most one load/store per
// instruction on a req/ack bus, and presents completed instructions to
// write-back as a one-cycle valid_m pulse with registered fields.
module pl_reg_e2m #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush,
  input  logic        valid_e,
  input  logic [31:0] alu_result_e,
  input  logic [31:0] rs2_e,
  input  logic [31:0] next_pc_e,
  input  logic [2:0]  funct3_e,
  input  logic [1:0]  wb_sel_e,
  input  logic [4:0]  rd_e,
  input  logic        regwe_e,
  input  logic        memwe_e,
  input  logic        memre_e,
  input  logic        csrwe_e,
  input  logic [11:0] csraddr_e,
  input  logic [31:0] csrrdata_e,
  output logic        stall_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] next_pc_m,
  output logic [31:0] csrrdata_m,
  output logic [31:0] load_word_m,
  output logic [2:0]  funct3_m,
  output logic [1:0]  wb_sel_m,
  output logic [4:0]  rd_m,
  output logic        regwe_m,
  output logic        csrwe_m,
  output logic [11:0] csraddr_m,
  output logic        misalign_m,
  output logic        buserr_m
);

  localparam int CNT_W = $clog2(DMEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Size encodings come from funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   misaligned_f = a[0];
      2'b10:   misaligned_f = |a;
      default: misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   be_f = 4'b0001 << a;
      2'b01:   be_f = a[1] ? 4'b1100 : 4'b0011;
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   wdata_f = {4{d[7:0]}};
      2'b01:   wdata_f = {2{d[15:0]}};
      default: wdata_f = d;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  // M slot: control (reset) and data (no reset) halves
  logic        slot_regwe_q, slot_memwe_q, slot_csrwe_q, slot_mis_q;
  logic [4:0]  slot_rd_q;
  logic [31:0] slot_alu_q, slot_rs2_q, slot_npc_q, slot_csrrd_q;
  logic [2:0]  slot_f3_q;
  logic [1:0]  slot_wbsel_q;
  logic [11:0] slot_csraddr_q;

  // Completed-instruction bank next values
  logic        valid_d, regwe_d, csrwe_d, misalign_d, buserr_d;
  logic [31:0] alu_result_d, next_pc_d, csrrdata_d, load_word_d;
  logic [2:0]  funct3_d;
  logic [1:0]  wb_sel_d;
  logic [4:0]  rd_d;
  logic [11:0] csraddr_d;

  logic cap, cap_vld, cap_memop, cap_mis, cap_acc, cap_done;
  logic in_acc, acc_ack, acc_to, acc_end;

  assign in_acc    = (state_q == S_ACCESS);
  assign stall_e   = in_acc && !dmem_ack;
  assign acc_ack   = in_acc && dmem_ack;
  assign acc_to    = in_acc && !dmem_ack && (cnt_q == CNT_MAX);
  assign acc_end   = acc_ack || acc_to;

  assign cap       = !stall_e;
  assign cap_vld   = cap && valid_e && !flush;
  assign cap_memop = memwe_e || memre_e;
  assign cap_mis   = cap_memop && misaligned_f(funct3_e[1:0], alu_result_e[1:0]);
  assign cap_acc   = cap_vld && cap_memop && !cap_mis;
  assign cap_done  = cap_vld && !(cap_memop && !cap_mis);

  // Bus drive: request held for the whole ACCESS state, fields from the slot
  assign dmem_req   = in_acc;
  assign dmem_we    = in_acc && slot_memwe_q;
  assign dmem_addr  = in_acc ? {slot_alu_q[31:2], 2'b00} : 32'd0;
  assign dmem_be    = in_acc ? be_f(slot_f3_q[1:0], slot_alu_q[1:0]) : 4'd0;
  assign dmem_wdata = in_acc ? wdata_f(slot_f3_q[1:0], slot_rs2_q) : 32'd0;

  // Next-state and access counter. The counter restarts whenever a new
  // access begins and saturates at its terminal count.
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    if (in_acc && !acc_end) begin
      state_d = S_ACCESS;
    end else if (cap_acc) begin
      state_d = S_ACCESS;
    end else if (valid_d) begin
      state_d = S_DONE;
    end
    if (cap_acc) begin
      cnt_d = '0;
    end else if (in_acc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Completion bank. An access finishing on the same edge that captures a
  // non-memory op leaves that op parked in the slot (pend) for one cycle,
  // so it is presented right after the access instead of being lost.
  always_comb begin
    valid_d      = 1'b0;
    alu_result_d = alu_result_m;
    next_pc_d    = next_pc_m;
    csrrdata_d   = csrrdata_m;
    load_word_d  = load_word_m;
    funct3_d     = funct3_m;
    wb_sel_d     = wb_sel_m;
    rd_d         = rd_m;
    regwe_d      = regwe_m;
    csrwe_d      = csrwe_m;
    csraddr_d    = csraddr_m;
    misalign_d   = misalign_m;
    buserr_d     = buserr_m;
    if (acc_end || pend_q) begin
      valid_d      = 1'b1;
      alu_result_d = slot_alu_q;
      next_pc_d    = slot_npc_q;
      csrrdata_d   = slot_csrrd_q;
      funct3_d     = slot_f3_q;
      wb_sel_d     = slot_wbsel_q;
      rd_d         = slot_rd_q;
      csraddr_d    = slot_csraddr_q;
      if (acc_end) begin
        load_word_d = acc_ack ? dmem_rdata : 32'd0;
        regwe_d     = slot_regwe_q && acc_ack;
        csrwe_d     = slot_csrwe_q && acc_ack;
        misalign_d  = 1'b0;
        buserr_d    = acc_to;
      end else begin
        load_word_d = 32'd0;
        regwe_d     = slot_regwe_q && !slot_mis_q;
        csrwe_d     = slot_csrwe_q && !slot_mis_q;
        misalign_d  = slot_mis_q;
        buserr_d    = 1'b0;
      end
    end else if (cap_done) begin
      valid_d      = 1'b1;
      alu_result_d = alu_result_e;
      next_pc_d    = next_pc_e;
      csrrdata_d   = csrrdata_e;
      load_word_d  = 32'd0;
      funct3_d     = funct3_e;
      wb_sel_d     = wb_sel_e;
      rd_d         = rd_e;
      regwe_d      = regwe_e && !cap_mis;
      csrwe_d      = csrwe_e && !cap_mis;
      csraddr_d    = csraddr_e;
      misalign_d   = cap_mis;
      buserr_d     = 1'b0;
    end
  end

  assign pend_d = (acc_end || pend_q) && cap_done;

  // FSM state, access counter and park flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Slot control capture; bubbles clear the enables and rd
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_regwe_q <= 1'b0;
      slot_memwe_q <= 1'b0;
      slot_csrwe_q <= 1'b0;
      slot_mis_q   <= 1'b0;
      slot_rd_q    <= 5'd0;
    end else if (cap) begin
      slot_regwe_q <= cap_vld && regwe_e;
      slot_memwe_q <= cap_vld && memwe_e;
      slot_csrwe_q <= cap_vld && csrwe_e;
      slot_mis_q   <= cap_vld && cap_mis;
      slot_rd_q    <= cap_vld ? rd_e : 5'd0;
    end
  end

  // Slot data capture; held stable while the access is stalled
  always_ff @(posedge clk_in) begin
    if (cap) begin
      slot_alu_q     <= alu_result_e;
      slot_rs2_q     <= rs2_e;
      slot_npc_q     <= next_pc_e;
      slot_csrrd_q   <= csrrdata_e;
      slot_f3_q      <= funct3_e;
      slot_wbsel_q   <= wb_sel_e;
      slot_csraddr_q <= csraddr_e;
    end
  end

  // Completed-instruction outputs to write-back
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_m      <= 1'b0;
      alu_result_m <= 32'd0;
      next_pc_m    <= 32'd0;
      csrrdata_m   <= 32'd0;
      load_word_m  <= 32'd0;
      funct3_m     <= 3'd0;
      wb_sel_m     <= 2'd0;
      rd_m         <= 5'd0;
      regwe_m      <= 1'b0;
      csrwe_m      <= 1'b0;
      csraddr_m    <= 12'd0;
      misalign_m   <= 1'b0;
      buserr_m     <= 1'b0;
    end else begin
      valid_m      <= valid_d;
      alu_result_m <= alu_result_d;
      next_pc_m    <= next_pc_d;
      csrrdata_m   <= csrrdata_d;
      load_word_m  <= load_word_d;
      funct3_m     <= funct3_d;
      wb_sel_m     <= wb_sel_d;
      rd_m         <= rd_d;
      regwe_m      <= regwe_d;
      csrwe_m      <= csrwe_d;
      csraddr_m    <= csraddr_d;
      misalign_m   <= misalign_d;
      buserr_m     <= buserr_d;
    end
  end

endmodule

// File: tb/tb_pl_reg_e2m.sv
// Directed bench for pl_reg_e2m: each step drives inputs just after a rising
// edge and checks outputs with immediate assertions before the next edge.
module tb_pl_reg_e2m;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush, valid_e;
  logic [31:0] alu_result_e, rs2_e, next_pc_e, csrrdata_e;
  logic [2:0]  funct3_e;
  logic [1:0]  wb_sel_e;
  logic [4:0]  rd_e;
  logic        regwe_e, memwe_e, memre_e, csrwe_e;
  logic [11:0] csraddr_e;
  logic        stall_e, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_m;
  logic [31:0] alu_result_m, next_pc_m, csrrdata_m, load_word_m;
  logic [2:0]  funct3_m;
  logic [1:0]  wb_sel_m;
  logic [4:0]  rd_m;
  logic        regwe_m, csrwe_m;
  logic [11:0] csraddr_m;
  logic        misalign_m, buserr_m;

  int total = 0;
  int bad   = 0;

  pl_reg_e2m #(.DMEM_TIMEOUT(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush), .valid_e(valid_e),
    .alu_result_e(alu_result_e), .rs2_e(rs2_e), .next_pc_e(next_pc_e),
    .funct3_e(funct3_e), .wb_sel_e(wb_sel_e), .rd_e(rd_e), .regwe_e(regwe_e),
    .memwe_e(memwe_e), .memre_e(memre_e), .csrwe_e(csrwe_e),
    .csraddr_e(csraddr_e), .csrrdata_e(csrrdata_e), .stall_e(stall_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .valid_m(valid_m), .alu_result_m(alu_result_m),
    .next_pc_m(next_pc_m), .csrrdata_m(csrrdata_m), .load_word_m(load_word_m),
    .funct3_m(funct3_m), .wb_sel_m(wb_sel_m), .rd_m(rd_m), .regwe_m(regwe_m),
    .csrwe_m(csrwe_m), .csraddr_m(csraddr_m), .misalign_m(misalign_m),
    .buserr_m(buserr_m)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle_in();
    valid_e = 0; flush = 0; alu_result_e = 0; rs2_e = 0; next_pc_e = 0;
    csrrdata_e = 0; funct3_e = 0; wb_sel_e = 0; rd_e = 0; regwe_e = 0;
    memwe_e = 0; memre_e = 0; csrwe_e = 0; csraddr_e = 0;
  endtask

  task automatic op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                    input logic [4:0] rd, input logic rwe, input logic mwe, input logic mre);
    idle_in();
    valid_e = 1; alu_result_e = alu; rs2_e = rs2; funct3_e = f3; rd_e = rd;
    regwe_e = rwe; memwe_e = mwe; memre_e = mre;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    rst_in = 1; dmem_ack = 0; dmem_rdata = 0;
    idle_in();
    step(); step();
    chk("rst_valid_m", valid_m, 0);
    chk("rst_stall", stall_e, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_rd_m", rd_m, 0);
    rst_in = 0;
    step();

    // ADD: one cycle capture -> valid_m
    op(32'h1234, 0, 3'b000, 5'd5, 1, 0, 0);
    next_pc_e = 32'h1004; csraddr_e = 12'h305;
    #1 chk("add_stall", stall_e, 0);
    step(); idle_in();
    chk("add_valid", valid_m, 1);
    chk("add_rd", rd_m, 5);
    chk("add_alu", alu_result_m, 32'h1234);
    chk("add_npc", next_pc_m, 32'h1004);
    chk("add_regwe", regwe_m, 1);
    chk("add_csraddr", csraddr_m, 12'h305);
    chk("add_req", dmem_req, 0);
    chk("add_stall2", stall_e, 0);
    step();
    chk("add_pulse_end", valid_m, 0);

    // SW 0x100, ack on third ACCESS cycle
    op(32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 1, 0);
    step(); idle_in();
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_be", dmem_be, 4'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_stall1", stall_e, 1);
    chk("sw_valid_early", valid_m, 0);
    step();
    chk("sw_stall2", stall_e, 1);
    step();
    dmem_ack = 1;
    #1 chk("sw_ack_stall", stall_e, 0);
    chk("sw_ack_req", dmem_req, 1);
    step(); dmem_ack = 0;
    chk("sw_valid", valid_m, 1);
    chk("sw_req_off", dmem_req, 0);
    chk("sw_buserr", buserr_m, 0);
    step();

    // SB 0x103
    op(32'h103, 32'h000000AB, 3'b000, 0, 0, 1, 0);
    step(); idle_in();
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h100);
    dmem_ack = 1;
    step(); dmem_ack = 0;
    chk("sb_valid", valid_m, 1);
    step();

    // LH 0x202
    op(32'h202, 0, 3'b001, 5'd7, 1, 0, 1);
    step(); idle_in();
    chk("lh_be", dmem_be, 4'b1100);
    chk("lh_we", dmem_we, 0);
    chk("lh_addr", dmem_addr, 32'h200);
    dmem_ack = 1; dmem_rdata = 32'h55667788;
    step(); dmem_ack = 0; dmem_rdata = 0;
    chk("lh_valid", valid_m, 1);
    chk("lh_load", load_word_m, 32'h55667788);
    chk("lh_rd", rd_m, 7);
    chk("lh_regwe", regwe_m, 1);
    chk("lh_f3", funct3_m, 3'b001);
    step();

    // LW 0x101 misaligned
    op(32'h101, 0, 3'b010, 5'd9, 1, 0, 1);
    step(); idle_in();
    chk("mis_req", dmem_req, 0);
    chk("mis_valid", valid_m, 1);
    chk("mis_flag", misalign_m, 1);
    chk("mis_regwe", regwe_m, 0);
    chk("mis_stall", stall_e, 0);
    step();

    // LW 0x300 with ack withheld: 16 ACCESS cycles then bus error
    op(32'h300, 0, 3'b010, 5'd3, 1, 0, 1);
    step(); idle_in();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (dmem_req) n++;
      step();
    end
    chk("to_req_cycles", n, 16);
    chk("to_req_off", dmem_req, 0);
    chk("to_valid", valid_m, 1);
    chk("to_buserr", buserr_m, 1);
    chk("to_regwe", regwe_m, 0);
    step();

    // Flush at capture of a SW
    op(32'h100, 32'h1, 3'b010, 0, 0, 1, 0);
    flush = 1;
    step(); idle_in();
    chk("fl_req", dmem_req, 0);
    chk("fl_valid", valid_m, 0);
    step();
    chk("fl_valid2", valid_m, 0);

    // Flush during a stall: access completes, held op is bubbled on ack edge
    op(32'h400, 32'h11223344, 3'b010, 0, 0, 1, 0);
    step();
    flush = 1;
    chk("fs_req", dmem_req, 1);
    step();
    chk("fs_req2", dmem_req, 1);
    chk("fs_addr", dmem_addr, 32'h400);
    dmem_ack = 1;
    #1 chk("fs_ack_stall", stall_e, 0);
    step(); dmem_ack = 0; idle_in();
    chk("fs_valid", valid_m, 1);
    chk("fs_buserr", buserr_m, 0);
    step();
    chk("fs_valid_end", valid_m, 0);
    chk("fs_no_reissue", dmem_req, 0);

    // Back-to-back non-memory ops
    op(32'h11, 0, 3'b000, 5'd1, 1, 0, 0);
    step();
    op(32'h22, 0, 3'b000, 5'd2, 1, 0, 0);
    chk("b2b_rd1", rd_m, 1);
    step(); idle_in();
    chk("b2b_valid2", valid_m, 1);
    chk("b2b_rd2", rd_m, 2);
    chk("b2b_alu2", alu_result_m, 32'h22);
    step();
    chk("b2b_end", valid_m, 0);

    // Load completing on the same edge an ADD is captured
    op(32'h600, 0, 3'b010, 5'd4, 1, 0, 1);
    step();
    op(32'h66, 0, 3'b000, 5'd6, 1, 0, 0);
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    step(); dmem_ack = 0; dmem_rdata = 0; idle_in();
    chk("col_valid1", valid_m, 1);
    chk("col_rd1", rd_m, 4);
    chk("col_load1", load_word_m, 32'hCAFEF00D);
    step();
    chk("col_valid2", valid_m, 1);
    chk("col_rd2", rd_m, 6);
    chk("col_alu2", alu_result_m, 32'h66);
    step();
    chk("col_end", valid_m, 0);

    // Reset pulse mid-ACCESS
    op(32'h500, 0, 3'b010, 5'd8, 1, 0, 1);
    step(); idle_in();
    chk("rs_req_pre", dmem_req, 1);
    chk("rs_stall_pre", stall_e, 1);
    rst_in = 1;
    #1;
    chk("rs_req", dmem_req, 0);
    chk("rs_stall", stall_e, 0);
    chk("rs_valid", valid_m, 0);
    step();
    rst_in = 0;
    step();
    chk("rs_idle_req", dmem_req, 0);
    chk("rs_idle_valid", valid_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
